// File: rtl/rmon_pkg.sv
// Shared types and helpers for the RMON counter reader: wide-counter width,
// reader FSM encoding and the modulo delta used to extend narrow counters.
package rmon_pkg;

  localparam int c_wide_cnt_w = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    UPD,
    NEXT
  } t_reader_state;

  // Increment of a free-running narrow counter between two samples, with wrap.
  function automatic logic [c_wide_cnt_w-1:0] f_cnt_delta(
    input logic [c_wide_cnt_w-1:0] cnt_new,
    input logic [c_wide_cnt_w-1:0] cnt_old,
    input int                      width
  );
    logic [c_wide_cnt_w-1:0] mask;
    if (width >= c_wide_cnt_w) mask = '1;
    else mask = (c_wide_cnt_w'(1) << width) - 1'b1;
    return (cnt_new - cnt_old) & mask;
  endfunction

endpackage

// File: rtl/rmon_cnt_accu.sv
// Wide-counter storage: per-index last sample, sync flag and 32-bit accumulator,
// one update port driven by the sweep FSM and a registered host read port.
module rmon_cnt_accu
  import rmon_pkg::*;
#(
  parameter int g_cnt_pp = 64,
  parameter int g_cnt_pw = 4,
  localparam int c_aw = $clog2(g_cnt_pp)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clear_i,
  input  logic                    upd_en_i,
  input  logic [c_aw-1:0]         upd_idx_i,
  input  logic [g_cnt_pw-1:0]     upd_data_i,
  input  logic                    host_rd_i,
  input  logic [c_aw-1:0]         host_addr_i,
  output logic [c_wide_cnt_w-1:0] host_data_o,
  output logic                    host_ack_o
);

  logic [c_wide_cnt_w-1:0] wide [g_cnt_pp];
  logic [g_cnt_pw-1:0]     last [g_cnt_pp];
  logic [g_cnt_pp-1:0]     sync;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < g_cnt_pp; i++) begin
        wide[i] <= '0;
        last[i] <= '0;
      end
      sync        <= '0;
      host_data_o <= '0;
      host_ack_o  <= 1'b0;
    end else begin
      // Non-blocking read gives the host the pre-update value on a collision.
      host_ack_o <= host_rd_i;
      if (host_rd_i) host_data_o <= wide[host_addr_i];

      if (clear_i) begin
        for (int i = 0; i < g_cnt_pp; i++) wide[i] <= '0;
        sync <= '0;
      end else if (upd_en_i) begin
        last[upd_idx_i] <= upd_data_i;
        if (!sync[upd_idx_i]) begin
          sync[upd_idx_i] <= 1'b1;
        end else begin
          wide[upd_idx_i] <= wide[upd_idx_i] +
            f_cnt_delta(c_wide_cnt_w'(upd_data_i), c_wide_cnt_w'(last[upd_idx_i]), g_cnt_pw);
        end
      end
    end
  end

endmodule

// File: rtl/rmon_cnt_reader.sv
// Periodic sweeper of the narrow RMON counters; feeds samples into the wide
// accumulator store and exposes it to the host.
//
// state | meaning
// IDLE  | wait for the period timer to reach the sweep start
// REQ   | read request for the current index, waiting for ack or timeout
// UPD   | fold the captured sample into the wide counter
// NEXT  | advance the index or finish the sweep
module rmon_cnt_reader
  import rmon_pkg::*;
#(
  parameter int g_cnt_pp      = 64,
  parameter int g_cnt_pw      = 4,
  parameter int g_scan_period = 256,
  parameter int g_ack_timeout = 15,
  localparam int c_aw = $clog2(g_cnt_pp)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  output logic                    rd_req_o,
  output logic [c_aw-1:0]         rd_addr_o,
  input  logic [g_cnt_pw-1:0]     rd_data_i,
  input  logic                    rd_ack_i,
  input  logic                    host_rd_i,
  input  logic [c_aw-1:0]         host_addr_i,
  output logic [c_wide_cnt_w-1:0] host_data_o,
  output logic                    host_ack_o,
  input  logic                    clear_i,
  output logic                    sweep_done_o,
  output logic                    timeout_o
);

  localparam int c_pw = $clog2(g_scan_period);
  localparam int c_tw = $clog2(g_ack_timeout + 1);
  localparam logic [c_pw-1:0] c_period_last = c_pw'(g_scan_period - 1);
  localparam logic [c_tw-1:0] c_wait_init   = c_tw'(g_ack_timeout - 1);
  localparam logic [c_aw-1:0] c_idx_last    = c_aw'(g_cnt_pp - 1);

  t_reader_state         state, next_state;
  logic [c_aw-1:0]       idx;
  logic [c_pw-1:0]       period_cnt;
  logic [c_tw-1:0]       wait_cnt;
  logic [g_cnt_pw-1:0]   data_q;
  logic                  timeout_q;
  logic                  upd_en;
  logic                  timeout_hit;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      idx        <= '0;
      period_cnt <= '0;
      wait_cnt   <= '0;
      data_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= next_state;
      period_cnt <= (period_cnt == c_period_last) ? '0 : period_cnt + 1'b1;
      case (state)
        IDLE: begin
          idx      <= '0;
          wait_cnt <= c_wait_init;
        end
        REQ: begin
          if (rd_ack_i) data_q <= rd_data_i;
          else if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        end
        NEXT: begin
          wait_cnt <= c_wait_init;
          if (idx != c_idx_last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
      // A fresh timeout in the clearing cycle is kept so it is not lost.
      if (clear_i) timeout_q <= 1'b0;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (period_cnt == c_period_last) next_state = REQ;
      REQ: begin
        if (rd_ack_i) next_state = UPD;
        else if (wait_cnt == '0) next_state = NEXT;
      end
      UPD:  next_state = NEXT;
      NEXT: next_state = (idx == c_idx_last) ? IDLE : REQ;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_req_o     = 1'b0;
    sweep_done_o = 1'b0;
    upd_en       = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      REQ: begin
        rd_req_o    = 1'b1;
        timeout_hit = !rd_ack_i && (wait_cnt == '0);
      end
      UPD:  upd_en = 1'b1;
      NEXT: sweep_done_o = (idx == c_idx_last);
      default: ;
    endcase
  end

  assign rd_addr_o = idx;
  assign timeout_o = timeout_q;

  rmon_cnt_accu #(
    .g_cnt_pp (g_cnt_pp),
    .g_cnt_pw (g_cnt_pw)
  ) u_accu (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clear_i     (clear_i),
    .upd_en_i    (upd_en),
    .upd_idx_i   (idx),
    .upd_data_i  (data_q),
    .host_rd_i   (host_rd_i),
    .host_addr_i (host_addr_i),
    .host_data_o (host_data_o),
    .host_ack_o  (host_ack_o)
  );

endmodule

// File: tb/tb_rmon_cnt_reader.sv
// Scoreboard bench for rmon_cnt_reader: a scripted counter-block responder,
// host reads queued with hand-computed values and checked by a monitor.
module tb_rmon_cnt_reader;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        rd_req_o;
  logic [5:0]  rd_addr_o;
  logic [3:0]  rd_data_i = '0;
  logic        rd_ack_i = 1'b0;
  logic        host_rd_i = 1'b0;
  logic [5:0]  host_addr_i = '0;
  logic [31:0] host_data_o;
  logic        host_ack_o;
  logic        clear_i = 1'b0;
  logic        sweep_done_o;
  logic        timeout_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  resp [64];
  int          withhold = -1;

  rmon_cnt_reader dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .rd_req_o     (rd_req_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i),
    .rd_ack_i     (rd_ack_i),
    .host_rd_i    (host_rd_i),
    .host_addr_i  (host_addr_i),
    .host_data_o  (host_data_o),
    .host_ack_o   (host_ack_o),
    .clear_i      (clear_i),
    .sweep_done_o (sweep_done_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Counter block model: one-cycle ack the cycle after a request is seen.
  initial begin
    forever begin
      @(negedge clk_i);
      rd_ack_i  = rd_req_o && !rd_ack_i && (int'(rd_addr_o) != withhold);
      rd_data_i = resp[rd_addr_o];
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (host_ack_o) begin
        if (exp_q.size() == 0) check("host_unexpected_ack", 32'd1, 32'd0);
        else check("host_data", host_data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic host_read(input logic [5:0] a, input logic [31:0] e);
    @(negedge clk_i);
    host_rd_i   = 1'b1;
    host_addr_i = a;
    exp_q.push_back(e);
    @(negedge clk_i);
    host_rd_i = 1'b0;
  endtask

  task automatic wait_sweep();
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!sweep_done_o && n < 1000);
    check("sweep_done_seen", sweep_done_o, 1'b1);
    @(negedge clk_i);
    check("sweep_done_one_cycle", sweep_done_o, 1'b0);
  endtask

  task automatic wait_req(input int a, input bit need_ack);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 1000) begin
      @(negedge clk_i);
      #1;
      n++;
      hit = rd_req_o && (int'(rd_addr_o) == a) && (!need_ack || rd_ack_i);
    end
    check("req_seen", 32'(hit), 32'd1);
  endtask

  task automatic pulse_clear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) resp[i] = 4'd5;
    repeat (3) @(negedge clk_i);
    check("reset_rd_req", rd_req_o, 1'b0);
    check("reset_rd_addr", rd_addr_o, 6'd0);
    check("reset_sweep_done", sweep_done_o, 1'b0);
    check("reset_timeout", timeout_o, 1'b0);
    check("reset_host_ack", host_ack_o, 1'b0);
    check("reset_host_data", host_data_o, 32'd0);
    rst_n_i = 1'b1;

    // Static data: baseline then zero delta.
    wait_sweep();
    wait_sweep();
    host_read(6'd0, 32'd0);
    host_read(6'd5, 32'd0);
    host_read(6'd63, 32'd0);

    // Baseline 2 -> 9 gives 7; narrow wrap 14 -> 3 gives 5.
    pulse_clear();
    resp[0] = 4'd2; resp[1] = 4'd14; resp[3] = 4'd0;
    wait_sweep();
    host_read(6'd0, 32'd0);
    resp[0] = 4'd9; resp[1] = 4'd3; resp[3] = 4'd10;
    wait_sweep();
    host_read(6'd0, 32'd7);
    host_read(6'd1, 32'd5);
    host_read(6'd3, 32'd10);
    host_read(6'd2, 32'd0);

    // Host read collides with the update of index 3 (10 -> 14).
    resp[3] = 4'd14;
    wait_req(3, 1);
    @(negedge clk_i);
    host_rd_i = 1'b1; host_addr_i = 6'd3; exp_q.push_back(32'd10);
    @(negedge clk_i);
    exp_q.push_back(32'd14);
    @(negedge clk_i);
    host_rd_i = 1'b0;
    wait_sweep();
    host_read(6'd0, 32'd7);
    host_read(6'd1, 32'd5);
    host_read(6'd3, 32'd14);

    // Ack withheld on index 10.
    check("timeout_before", timeout_o, 1'b0);
    withhold = 10;
    wait_req(10, 0);
    n = 0;
    while (!timeout_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check("timeout_latency", 32'(n), 32'd15);
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (!rd_req_o && n < 100);
    check("addr_after_timeout", rd_addr_o, 6'd11);
    withhold = -1;
    wait_sweep();
    check("timeout_sticky", timeout_o, 1'b1);
    pulse_clear();
    check("timeout_cleared", timeout_o, 1'b0);

    // Build nonzero counts, then clear in the middle of a sweep.
    resp[0] = 4'd1; resp[50] = 4'd2;
    wait_sweep();
    resp[0] = 4'd4; resp[50] = 4'd7;
    wait_sweep();
    host_read(6'd0, 32'd3);
    host_read(6'd50, 32'd5);
    resp[0] = 4'd8; resp[40] = 4'd5;
    wait_req(30, 0);
    pulse_clear();
    wait_sweep();
    host_read(6'd0, 32'd0);
    host_read(6'd30, 32'd0);
    host_read(6'd40, 32'd0);
    host_read(6'd50, 32'd0);
    wait_sweep();
    host_read(6'd0, 32'd0);
    host_read(6'd40, 32'd0);
    host_read(6'd50, 32'd0);
    resp[0] = 4'd11; resp[40] = 4'd15; resp[50] = 4'd2;
    wait_sweep();
    host_read(6'd0, 32'd3);
    host_read(6'd40, 32'd10);
    host_read(6'd50, 32'd11);

    repeat (5) @(negedge clk_i);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
